// File: rtl/io_pkg.sv
// Shared constants and types for the IO/timer register block: register
// addresses, CMD action encoding, timer state and the STAT word layout.
package io_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 14;

  // Register map
  localparam logic [ADDR_W-1:0] ADDR_CMD  = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_PA   = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_PB   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_TML  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_TMH  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_STAT = 3'd5;

  // CMD[7:6] write-only action field
  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_RSVD  = 2'b10,
    CMD_START = 2'b11
  } cmd_act_t;

  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } tmr_state_t;

  // STAT = {0, tc_flag, 00000, running}
  function automatic logic [DATA_W-1:0] stat_word(input logic tc_flag, input logic running);
    return {1'b0, tc_flag, 5'b00000, running};
  endfunction

endpackage

// File: rtl/io_timer_regs_if.sv
// Multiplexed address/data bus between the bus FSM (master) and the
// register block (slave). Strobes are active-high.
interface io_timer_regs_if;

  logic                        load;
  logic                        OEb;
  logic                        WR_RDb;
  logic [io_pkg::DATA_W-1:0]   ad_in;
  logic [io_pkg::DATA_W-1:0]   ad_out;
  logic                        ad_oe;

  modport master (
    output load,
    output OEb,
    output WR_RDb,
    output ad_in,
    input  ad_out,
    input  ad_oe
  );

  modport slave (
    input  load,
    input  OEb,
    input  WR_RDb,
    input  ad_in,
    output ad_out,
    output ad_oe
  );

endinterface

// File: rtl/io_timer_count.sv
// 14-bit down counter with start/stop, one-shot or auto-reload, and a
// registered one-cycle terminal-count pulse. A loaded value of 0 counts
// 16384 ticks because the first decrement wraps to 0x3FFF.
module io_timer_count
  import io_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] reload_i,
  input  logic             auto_i,
  output logic             running_o,
  output logic             tc_hit_o,
  output logic             tc_pulse_o
);

  tmr_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tc_pulse_q, tc_pulse_d;
  logic             tc_hit;

  // State, count and terminal-count pulse registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= TMR_IDLE;
      count_q    <= '0;
      tc_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      tc_pulse_q <= tc_pulse_d;
    end
  end

  // Next state: decrement on tick, terminal count at 1, start overrides all
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_hit  = (state_q == TMR_RUN) && tick_i && (count_q == CNT_W'(1));

    if ((state_q == TMR_RUN) && tick_i) begin
      if (tc_hit) begin
        if (auto_i) begin
          count_d = reload_i;
        end else begin
          count_d = '0;
          state_d = TMR_IDLE;
        end
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end

    if (stop_i) begin
      state_d = TMR_IDLE;
    end

    // A start in the same cycle as terminal count still lets the pulse out
    if (start_i) begin
      count_d = reload_i;
      state_d = TMR_RUN;
    end

    tc_pulse_d = tc_hit;
  end

  assign running_o  = (state_q == TMR_RUN);
  assign tc_hit_o   = tc_hit;
  assign tc_pulse_o = tc_pulse_q;

endmodule

// File: rtl/io_timer_regs.sv
// Register block behind a multiplexed address/data bus: command register,
// output port A, sampled input port B, a 14-bit timer and its status.
module io_timer_regs
  import io_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  io_timer_regs_if.slave    bus,
  input  logic [DATA_W-1:0] pb_in,
  output logic [DATA_W-1:0] pa_out,
  input  logic              tmr_in,
  output logic              tmr_out
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [5:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] pa_q, pa_d;
  logic [DATA_W-1:0] pb_q;
  logic [DATA_W-1:0] tml_q, tml_d;
  logic [DATA_W-1:0] tmh_q, tmh_d;
  logic              tc_flag_q, tc_flag_d;

  cmd_act_t          cmd_act;
  logic              start;
  logic              stop;
  logic              stat_rd;
  logic              running;
  logic              tc_hit;
  logic [DATA_W-1:0] rd_data;

  // Bus-visible registers and the port B input sample
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q    <= '0;
      cmd_q     <= '0;
      pa_q      <= '0;
      pb_q      <= '0;
      tml_q     <= '0;
      tmh_q     <= '0;
      tc_flag_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      pa_q      <= pa_d;
      pb_q      <= pb_in;
      tml_q     <= tml_d;
      tmh_q     <= tmh_d;
      tc_flag_q <= tc_flag_d;
    end
  end

  // Address latch, register writes (using the address latched earlier) and CMD decode
  always_comb begin
    addr_d  = bus.load ? bus.ad_in[ADDR_W-1:0] : addr_q;
    cmd_d   = cmd_q;
    pa_d    = pa_q;
    tml_d   = tml_q;
    tmh_d   = tmh_q;
    cmd_act = cmd_act_t'(bus.ad_in[7:6]);

    if (bus.WR_RDb) begin
      case (addr_q)
        ADDR_CMD: cmd_d = bus.ad_in[5:0];
        ADDR_PA:  pa_d  = bus.ad_in;
        ADDR_TML: tml_d = bus.ad_in;
        ADDR_TMH: tmh_d = bus.ad_in;
        default:  ;
      endcase
    end

    start   = bus.WR_RDb && (addr_q == ADDR_CMD) && (cmd_act == CMD_START);
    stop    = bus.WR_RDb && (addr_q == ADDR_CMD) && (cmd_act == CMD_STOP);
    stat_rd = bus.OEb && (addr_q == ADDR_STAT);

    // Setting the flag wins over the read-to-clear
    if (tc_hit) begin
      tc_flag_d = 1'b1;
    end else if (stat_rd) begin
      tc_flag_d = 1'b0;
    end else begin
      tc_flag_d = tc_flag_q;
    end
  end

  // Read-data mux; unused addresses read as zero
  always_comb begin
    case (addr_q)
      ADDR_CMD:  rd_data = {2'b00, cmd_q};
      ADDR_PA:   rd_data = pa_q;
      ADDR_PB:   rd_data = pb_q;
      ADDR_TML:  rd_data = tml_q;
      ADDR_TMH:  rd_data = tmh_q;
      ADDR_STAT: rd_data = stat_word(tc_flag_q, running);
      default:   rd_data = '0;
    endcase
  end

  assign bus.ad_oe  = bus.OEb;
  assign bus.ad_out = bus.OEb ? rd_data : '0;
  assign pa_out     = pa_q;

  io_timer_count u_count (
    .clock      (clock),
    .reset      (reset),
    .start_i    (start),
    .stop_i     (stop),
    .tick_i     (tmr_in),
    .reload_i   ({tmh_q[5:0], tml_q}),
    .auto_i     (tmh_q[6]),
    .running_o  (running),
    .tc_hit_o   (tc_hit),
    .tc_pulse_o (tmr_out)
  );

endmodule

// File: tb/tb_io_timer_regs.sv
// Directed bench for io_timer_regs: bus access, port A/B, timer one-shot,
// auto-reload, priority corner cases and reset behaviour.
module tb_io_timer_regs;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] pb_in;
  logic [7:0] pa_out;
  logic       tmr_in;
  logic       tmr_out;

  int n_checks = 0;
  int n_pass   = 0;

  io_timer_regs_if bus ();

  io_timer_regs dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .pb_in   (pb_in),
    .pa_out  (pa_out),
    .tmr_in  (tmr_in),
    .tmr_out (tmr_out)
  );

  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    bus.load  = 1'b1;
    bus.ad_in = {5'b0, a};
    tick();
    bus.load   = 1'b0;
    bus.WR_RDb = 1'b1;
    bus.ad_in  = d;
    tick();
    bus.WR_RDb = 1'b0;
    bus.ad_in  = 8'h00;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d, output logic oe);
    bus.load  = 1'b1;
    bus.ad_in = {5'b0, a};
    tick();
    bus.load = 1'b0;
    bus.OEb  = 1'b1;
    #1;
    d  = bus.ad_out;
    oe = bus.ad_oe;
    tick();
    bus.OEb = 1'b0;
  endtask

  initial begin
    logic [7:0]  rd;
    logic        oe;
    logic [9:0]  pat;
    int          n;
    bit          found;

    reset      = 1'b1;
    pb_in      = 8'h00;
    tmr_in     = 1'b0;
    bus.load   = 1'b0;
    bus.OEb    = 1'b0;
    bus.WR_RDb = 1'b0;
    bus.ad_in  = 8'h00;
    tick();
    tick();
    chk_eq("rst_pa_out", pa_out, 8'h00);
    chk_eq("rst_ad_out", bus.ad_out, 8'h00);
    chk_eq("rst_ad_oe", bus.ad_oe, 1'b0);
    chk_eq("rst_tmr_out", tmr_out, 1'b0);
    reset = 1'b0;
    tick();
    bus_read(3'd5, rd, oe);
    chk_eq("rst_stat", rd, 8'h00);
    bus_read(3'd0, rd, oe);
    chk_eq("rst_cmd", rd, 8'h00);

    // Port A write and readback
    bus_write(3'd1, 8'hA5);
    chk_eq("pa_out", pa_out, 8'hA5);
    bus_read(3'd1, rd, oe);
    chk_eq("pa_read", rd, 8'hA5);
    chk_eq("pa_read_oe", oe, 1'b1);

    // Port B sample, writes ignored
    pb_in = 8'h3C;
    tick();
    tick();
    bus_read(3'd2, rd, oe);
    chk_eq("pb_read", rd, 8'h3C);
    bus_write(3'd2, 8'hFF);
    bus_read(3'd2, rd, oe);
    chk_eq("pb_ro", rd, 8'h3C);

    // CMD action bits read as 0, TMH bit7 stored, unmapped address
    bus_write(3'd0, 8'hBF);
    bus_read(3'd0, rd, oe);
    chk_eq("cmd_read", rd, 8'h3F);
    bus_write(3'd4, 8'h85);
    bus_read(3'd4, rd, oe);
    chk_eq("tmh_read", rd, 8'h85);
    bus_write(3'd6, 8'h55);
    bus_read(3'd6, rd, oe);
    chk_eq("addr6_read", rd, 8'h00);
    bus_read(3'd5, rd, oe);
    chk_eq("stat_idle", rd, 8'h00);

    // load and write together use the previously latched address
    bus_write(3'd3, 8'h77);
    bus.load  = 1'b1;
    bus.ad_in = 8'h01;
    tick();
    bus.WR_RDb = 1'b1;
    bus.ad_in  = 8'h03;
    tick();
    bus.load   = 1'b0;
    bus.WR_RDb = 1'b0;
    chk_eq("ldwr_pa", pa_out, 8'h03);
    bus.OEb = 1'b1;
    #1;
    chk_eq("ldwr_addr", bus.ad_out, 8'h77);
    tick();
    bus.OEb = 1'b0;

    // One-shot count of 3 with tmr_in held high
    bus_write(3'd3, 8'h03);
    bus_write(3'd4, 8'h00);
    tmr_in = 1'b1;
    bus_write(3'd0, 8'hC0);
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pat[i] = tmr_out;
    end
    chk_eq("oneshot_pulse", pat[3:0], 4'b0100);
    tmr_in = 1'b0;
    bus_read(3'd5, rd, oe);
    chk_eq("oneshot_stat1", rd, 8'h40);
    bus_read(3'd5, rd, oe);
    chk_eq("oneshot_stat2", rd, 8'h00);

    // Auto-reload every 2 ticks, then stop
    bus_write(3'd3, 8'h02);
    bus_write(3'd4, 8'h40);
    bus_write(3'd0, 8'hC0);
    tmr_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      pat[i] = tmr_out;
    end
    tmr_in = 1'b0;
    chk_eq("auto_pulses", pat, 10'b1010101010);
    bus_read(3'd5, rd, oe);
    chk_eq("auto_stat_run", rd, 8'h41);
    bus_write(3'd0, 8'h40);
    bus_read(3'd5, rd, oe);
    chk_eq("auto_stat_stop", rd, 8'h00);

    // Reload register writes while running do not disturb the count
    bus_write(3'd3, 8'h05);
    bus_write(3'd4, 8'h00);
    bus_write(3'd0, 8'hC0);
    tmr_in = 1'b1;
    tick();
    tmr_in = 1'b0;
    bus_write(3'd3, 8'h20);
    tmr_in = 1'b1;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      pat[i] = tmr_out;
    end
    tmr_in = 1'b0;
    chk_eq("tml_while_run", pat[5:0], 6'b001000);
    bus_read(3'd5, rd, oe);
    chk_eq("tml_while_run_stat", rd, 8'h40);

    // Terminal count in the same cycle as a STAT read keeps the flag
    bus_write(3'd3, 8'h02);
    bus_write(3'd0, 8'hC0);
    bus.load  = 1'b1;
    bus.ad_in = 8'h05;
    tick();
    bus.load = 1'b0;
    tmr_in   = 1'b1;
    tick();
    bus.OEb = 1'b1;
    #1;
    chk_eq("setwin_pre", bus.ad_out, 8'h01);
    tick();
    bus.OEb = 1'b0;
    tmr_in  = 1'b0;
    chk_eq("setwin_pulse", tmr_out, 1'b1);
    bus_read(3'd5, rd, oe);
    chk_eq("setwin_stat", rd, 8'h40);

    // Start coincident with terminal count restarts the timer
    bus_write(3'd0, 8'hC0);
    tmr_in = 1'b1;
    tick();
    bus.WR_RDb = 1'b1;
    bus.ad_in  = 8'hC0;
    tick();
    bus.WR_RDb = 1'b0;
    bus.ad_in  = 8'h00;
    pat    = '0;
    pat[0] = tmr_out;
    tick();
    pat[1] = tmr_out;
    tick();
    pat[2] = tmr_out;
    tmr_in = 1'b0;
    chk_eq("start_tc_pulses", pat[2:0], 3'b101);
    bus_read(3'd5, rd, oe);
    chk_eq("start_tc_stat", rd, 8'h40);

    // Loaded count 0 means 16384 ticks
    bus_write(3'd3, 8'h00);
    bus_write(3'd4, 8'h00);
    bus_write(3'd0, 8'hC0);
    tmr_in = 1'b1;
    n      = 0;
    found  = 1'b0;
    for (int i = 1; i <= 20000 && !found; i++) begin
      tick();
      if (tmr_out) begin
        found = 1'b1;
        n     = i;
      end
    end
    tmr_in = 1'b0;
    chk_eq("count0_ticks", n, 16384);

    // Reset on the cycle that would have been terminal count
    bus_write(3'd1, 8'h5A);
    bus_write(3'd3, 8'h06);
    bus_write(3'd0, 8'hC0);
    tmr_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    chk_eq("midrst_pa_out", pa_out, 8'h00);
    chk_eq("midrst_tmr_out", tmr_out, 1'b0);
    chk_eq("midrst_ad_oe", bus.ad_oe, 1'b0);
    chk_eq("midrst_ad_out", bus.ad_out, 8'h00);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tmr_out) n++;
    end
    tmr_in = 1'b0;
    chk_eq("midrst_no_pulse", n, 0);
    bus_read(3'd5, rd, oe);
    chk_eq("midrst_stat", rd, 8'h00);
    bus_read(3'd3, rd, oe);
    chk_eq("midrst_tml", rd, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/io_timer_regs.md
IO_TIMER_REGS -- requirements
Module: io_timer_regs

Interface
REQ-001 SHALL have ports: clock  in  1  single clock; all logic on posedge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: load  in  1  address-latch strobe from the bus FSM (START state).
REQ-004 SHALL have: OEb  in  1  read strobe from the bus FSM, active-high (READ state).
REQ-005 SHALL have: WR_RDb  in  1  write strobe from the bus FSM, active-high (WRITE state).
REQ-006 SHALL have: ad_in  in  8  multiplexed address/data bus input.
REQ-007 SHALL have: ad_out  out  8  read data; ad_oe  out  1  bus drive enable.
REQ-008 SHALL have: pb_in  in  8  port B input pins; pa_out  out  8  port A output register.
REQ-009 SHALL have: tmr_in  in  1  timer count-enable pulse; tmr_out  out  1  terminal-count pulse.

Function
REQ-010 SHALL latch addr = ad_in[2:0] on the cycle load=1; addr holds otherwise.
REQ-011 Register map SHALL be: 0 CMD, 1 PA, 2 PB, 3 TML, 4 TMH, 5 STAT; 6-7 read 0x00, writes ignored.
REQ-012 On WR_RDb=1, ad_in SHALL be written to reg[addr] at that clock edge; writes to PB and STAT ignored.
REQ-013 ad_oe SHALL equal OEb combinationally; ad_out = reg[addr] combinationally when OEb=1, else 0x00.
REQ-014 pa_out SHALL equal the PA register.
REQ-015 PB read SHALL return pb_in registered once per clock (1-cycle latency).
REQ-016 CMD[5:0] SHALL be stored; CMD[7:6] SHALL be write-only actions and read back as 00.
REQ-017 CMD[7:6]=11 SHALL load count from {TMH[5:0],TML} and set running next cycle; 01 SHALL clear running; 00/10 no action.
REQ-018 TMH[6]=1 SHALL select auto-reload mode; TMH[6]=0 one-shot; TMH[7] reserved, reads back as written.
REQ-019 While running, each clock with tmr_in=1 SHALL decrement the 14-bit count by 1.
REQ-020 Count=1 with tmr_in=1 SHALL be terminal count: tmr_out=1 for exactly that following cycle, STAT[6] set.
REQ-021 At terminal count: auto-reload SHALL reload {TMH[5:0],TML}; one-shot SHALL stop with count=0.
REQ-022 Loaded count 0 SHALL behave as 16384 (decrement wraps 0 -> 0x3FFF).
REQ-023 Writes to TML/TMH while running SHALL not change the count until next start or reload.
REQ-024 STAT SHALL read {1'b0, tc_flag, 5'b0, running}; reading STAT (OEb=1, addr=5) SHALL clear tc_flag.
REQ-025 Terminal count coincident with STAT read SHALL leave tc_flag set (set wins).
REQ-026 Start command coincident with terminal count SHALL take priority (count reloaded, running=1, tmr_out still pulses).
REQ-027 load and WR_RDb in the same cycle SHALL write using the previously latched addr.

Reset
REQ-028 reset SHALL clear addr, CMD, PA, PB sample, TML, TMH, count, running, tc_flag to 0.
REQ-029 During/after reset: pa_out=0x00, ad_out=0x00, ad_oe=0 (with OEb=0), tmr_out=0.
REQ-030 reset mid-count SHALL stop the timer immediately; no tmr_out pulse in the reset cycle.

Structure
REQ-031 Register address constants and CMD action encoding SHALL live in a shared package io_pkg.
REQ-032 The 14-bit counter, reload and terminal-count logic SHALL be one sub-module io_timer_count.

Verification
REQ-033 load with ad_in=0x01, then WR_RDb with ad_in=0xA5 -> pa_out=0xA5 next cycle; read addr 1 returns 0xA5 with ad_oe=1.
REQ-034 pb_in=0x3C, read addr 2 two cycles later -> ad_out=0x3C; write 0xFF to addr 2 -> read still 0x3C.
REQ-035 TML=0x03, TMH=0x00, CMD=0xC0, tmr_in held 1 -> tmr_out single pulse after 3rd pulse, running=0, STAT reads 0x40 then 0x00.
REQ-036 TML=0x02, TMH=0x40, start -> tmr_out pulses every 2 tmr_in pulses; CMD=0x40 stops, STAT[0]=0.
REQ-037 Start with TML=TMH=0x00 -> first tmr_out after 16384 pulses.
REQ-038 reset asserted mid-count -> all outputs 0 next cycle; later tmr_in pulses produce no tmr_out.
